// File: rtl/decode_pkg.sv
// Shared types for the RV64I decode stage: opcodes, instruction classes and
// the decoded-field bundle.
package decode_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] HALT_INSTR = 32'h00008067;
    localparam int unsigned IMM_W      = 64;

    typedef enum logic [3:0] {
        CLS_LUI       = 4'h0,
        CLS_AUIPC     = 4'h1,
        CLS_JAL       = 4'h2,
        CLS_JALR      = 4'h3,
        CLS_BRANCH    = 4'h4,
        CLS_LOAD      = 4'h5,
        CLS_STORE     = 4'h6,
        CLS_OP_IMM    = 4'h7,
        CLS_OP_IMM_32 = 4'h8,
        CLS_OP        = 4'h9,
        CLS_OP_32     = 4'hA,
        CLS_FENCE     = 4'hB,
        CLS_SYSTEM    = 4'hC,
        CLS_ILLEGAL   = 4'hF
    } inst_class_e;

    typedef struct packed {
        inst_class_e      cls;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [IMM_W-1:0] imm;
        logic             illegal;
        logic             halt;
    } dec_fields_t;

    // Any opcode with low bits other than 2'b11 falls through to illegal.
    function automatic inst_class_e decode_class(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI:       return CLS_LUI;
            OPC_AUIPC:     return CLS_AUIPC;
            OPC_JAL:       return CLS_JAL;
            OPC_JALR:      return CLS_JALR;
            OPC_BRANCH:    return CLS_BRANCH;
            OPC_LOAD:      return CLS_LOAD;
            OPC_STORE:     return CLS_STORE;
            OPC_OP_IMM:    return CLS_OP_IMM;
            OPC_OP_IMM_32: return CLS_OP_IMM_32;
            OPC_OP:        return CLS_OP;
            OPC_OP_32:     return CLS_OP_32;
            OPC_FENCE:     return CLS_FENCE;
            OPC_SYSTEM:    return CLS_SYSTEM;
            default:       return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// sign-extends from instr[31] to XLEN. R-type and unknown opcodes yield zero.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC:
                imm_o = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            OPC_BRANCH:
                imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            OPC_STORE:
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_FENCE, OPC_SYSTEM:
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: skid FIFO, combinational decode of the head, registered output.
// Define DECODE_TRACE_EN to print every output handshake in simulation.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_instr_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [3:0]      out_class_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [2:0]      out_funct3_o,
    output logic [6:0]      out_funct7_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic            out_illegal_o,
    output logic            out_halt_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            halted_q, halted_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    dec_fields_t     dec_q, dec_d, dec_next;

    logic            push, pop, adv, empty;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_imm;

    // Ready depends only on registered state so no path runs from out_ready_i.
    assign in_ready_o = !reset && (count_q < CntW'(FIFO_DEPTH)) && !halted_q;
    assign empty      = (count_q == '0);
    assign adv        = !out_valid_q || out_ready_i;
    assign push       = in_valid_i && in_ready_o && !flush_i;
    assign pop        = adv && !empty;
    assign head_instr = fifo_instr_q[rd_ptr_q];

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i (head_instr),
        .imm_o   (head_imm)
    );

    always_comb begin
        dec_next         = '0;
        dec_next.cls     = decode_class(head_instr[6:0]);
        dec_next.rd      = head_instr[11:7];
        dec_next.rs1     = head_instr[19:15];
        dec_next.rs2     = head_instr[24:20];
        dec_next.funct3  = head_instr[14:12];
        dec_next.funct7  = head_instr[31:25];
        dec_next.imm     = IMM_W'(head_imm);
        dec_next.illegal = (dec_next.cls == CLS_ILLEGAL) || (head_instr == 32'h0);
        dec_next.halt    = (head_instr == HALT_INSTR);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (in_instr_i == HALT_INSTR) halted_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        dec_d       = dec_q;
        if (adv) begin
            out_valid_d = !empty;
            if (!empty) begin
                out_pc_d = fifo_pc_q[rd_ptr_q];
                dec_d    = dec_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= in_pc_i;
            fifo_instr_q[wr_ptr_q] <= in_instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Flush only kills out_valid; stale data is harmless behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            dec_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            dec_q       <= dec_d;
        end
    end

`ifdef DECODE_TRACE_EN
    logic [31:0] instr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
        end else if (!flush_i && pop) begin
            instr_q <= head_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && out_valid_q && out_ready_i) begin
            $display("DEC pc=%x instr=%x cls=%0d", out_pc_q, instr_q, dec_q.cls);
        end
    end
`else
`endif

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_pc_q;
    assign out_class_o   = dec_q.cls;
    assign out_rd_o      = dec_q.rd;
    assign out_rs1_o     = dec_q.rs1;
    assign out_rs2_o     = dec_q.rs2;
    assign out_funct3_o  = dec_q.funct3;
    assign out_funct7_o  = dec_q.funct7;
    assign out_imm_o     = dec_q.imm[XLEN-1:0];
    assign out_illegal_o = dec_q.illegal;
    assign out_halt_o    = dec_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an in-order scoreboard of expected decodes.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [31:0] in_instr;
    logic [3:0]  out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal, out_halt;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [63:0] imm;
        logic        ill;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic [63:0] pc_ctr = 64'h8000_0000_0000_1000;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN       (64),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_pc_i       (in_pc),
        .in_instr_i    (in_instr),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_pc_o      (out_pc),
        .out_class_o   (out_class),
        .out_rd_o      (out_rd),
        .out_rs1_o     (out_rs1),
        .out_rs2_o     (out_rs2),
        .out_funct3_o  (out_funct3),
        .out_funct7_o  (out_funct7),
        .out_imm_o     (out_imm),
        .out_illegal_o (out_illegal),
        .out_halt_o    (out_halt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output handshakes pop the scoreboard; accepted pushes append to it.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            n_out++;
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_out observed pc=%h expected no output", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_class", 64'(out_class), 64'(e.cls));
                chk("out_rd", 64'(out_rd), 64'(e.instr[11:7]));
                chk("out_rs1", 64'(out_rs1), 64'(e.instr[19:15]));
                chk("out_rs2", 64'(out_rs2), 64'(e.instr[24:20]));
                chk("out_funct3", 64'(out_funct3), 64'(e.instr[14:12]));
                chk("out_funct7", 64'(out_funct7), 64'(e.instr[31:25]));
                chk("out_imm", out_imm, e.imm);
                chk("out_illegal", 64'(out_illegal), 64'(e.ill));
                chk("out_halt", 64'(out_halt), 64'(e.halt));
            end
        end
        if (reset || flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(cur);
    end

    task automatic offer(input logic [31:0] instr, input logic [3:0] cls,
                         input logic [63:0] imm, input logic ill);
        cur.pc    = pc_ctr;
        cur.instr = instr;
        cur.cls   = cls;
        cur.imm   = imm;
        cur.ill   = ill;
        cur.halt  = (instr == 32'h00008067);
        in_pc     = pc_ctr;
        in_instr  = instr;
        in_valid  = 1'b1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [3:0] cls,
                        input logic [63:0] imm, input logic ill);
        offer(instr, cls, imm, ill);
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        assert (in_ready)
        else begin
            errors++;
            $error("FAIL push_timeout observed in_ready=0 expected 1 instr=%h", instr);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pc_ctr += 4;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_pc     = '0;
        in_instr  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_class", 64'(out_class), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // addi x1,x0,5: visible the cycle after it lands in the FIFO
        push(32'h00500093, 4'h7, 64'd5, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_pc", out_pc, pc_ctr - 64'd4);
        chk("lat_rd", 64'(out_rd), 64'd1);
        chk("lat_imm", out_imm, 64'd5);
        push(32'hFE000EE3, 4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'h002081B3, 4'h9, 64'd0, 1'b0);
        push(32'h402081BB, 4'hA, 64'd0, 1'b0);
        push(32'h0010009B, 4'h8, 64'd1, 1'b0);
        push(32'h00000073, 4'hC, 64'd0, 1'b0);
        drain();

        // Stalled consumer: three accepted, then backpressure
        out_ready = 1'b0;
        push(32'h123450B7, 4'h0, 64'h0000_0000_1234_5000, 1'b0);
        push(32'h80000117, 4'h1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        push(32'h008000EF, 4'h2, 64'd8, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        push(32'h00112423, 4'h6, 64'd8, 1'b0);
        drain();

        push(32'h00000000, 4'hF, 64'd0, 1'b1);
        push(32'h0000007F, 4'hF, 64'd0, 1'b1);
        drain();

        // Flush a full stage while a push is offered
        out_ready = 1'b0;
        push(32'hFFC12083, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'h00000013, 4'h7, 64'd0, 1'b0);
        push(32'h0000100F, 4'hB, 64'd0, 1'b0);
        chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
        offer(32'h00000073, 4'hC, 64'd0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_quiet", 64'(out_valid), 64'd0);

        // Reset with work in flight
        out_ready = 1'b0;
        push(32'h00000013, 4'h7, 64'd0, 1'b0);
        push(32'h00100113, 4'h7, 64'd1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_quiet", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // ret halts intake until flushed
        push(32'h00008067, 4'h3, 64'd0, 1'b0);
        chk("halt_in_ready", 64'(in_ready), 64'd0);
        offer(32'h00500093, 4'h7, 64'd5, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("halt_hold_in_ready", 64'(in_ready), 64'd0);
        drain();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("halt_flush_in_ready", 64'(in_ready), 64'd1);
        push(32'h00500093, 4'h7, 64'd5, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("total_outputs", 64'(n_out), 64'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
